// File: rtl/pe_pkg.sv
// Shared constants and helpers for the systolic processing element family.
// Optional saturation in proc_elem_pipe is selected with the PE_SAT_EN macro.
package pe_pkg;

    localparam int PE_DATA_W   = 8;
    localparam int PE_WEIGHT_W = 8;
    localparam int PE_ACC_W    = 24;
    localparam int PROD_W      = PE_DATA_W + PE_WEIGHT_W;

    // Largest representable value of a w-bit signed quantity.
    function automatic longint sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest representable value of a w-bit signed quantity.
    function automatic longint sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_weight_buf.sv
// Double-buffered weight: shadow register loaded from w_in, active register
// updated from the shadow on commit. Load+commit together bypasses w_in
// straight into the active register. Not gated by the pipeline enable.
module pe_weight_buf
    import pe_pkg::*;
#(
    parameter int WEIGHT_W = PE_WEIGHT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WEIGHT_W-1:0] w_in,
    input  logic                w_load,
    input  logic                w_commit,
    output logic [WEIGHT_W-1:0] w_shadow,
    output logic [WEIGHT_W-1:0] w_act
);

    logic [WEIGHT_W-1:0] w_shadow_q, w_shadow_d;
    logic [WEIGHT_W-1:0] w_act_q, w_act_d;

    // Next shadow/active weight; commit takes the value the shadow is about to hold.
    always_comb begin
        w_shadow_d = w_shadow_q;
        w_act_d    = w_act_q;
        if (w_load) begin
            w_shadow_d = w_in;
        end
        if (w_commit) begin
            w_act_d = w_shadow_d;
        end
    end

    // Weight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_shadow_q <= '0;
            w_act_q    <= '0;
        end else begin
            w_shadow_q <= w_shadow_d;
            w_act_q    <= w_act_d;
        end
    end

    assign w_shadow = w_shadow_q;
    assign w_act    = w_act_q;

endmodule

// File: rtl/proc_elem_pipe.sv
// Pipelined systolic PE: y_out = y_in + w*x_in (2 cycles), x_out = x_in
// delayed X_DELAY cycles. Define PE_SAT_EN to clamp y_out instead of wrapping.
module proc_elem_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W   = PE_DATA_W,
    parameter int WEIGHT_W = PE_WEIGHT_W,
    parameter int ACC_W    = PE_ACC_W,
    parameter int X_DELAY  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DATA_W-1:0]   x_in,
    input  logic                x_valid_in,
    input  logic [ACC_W-1:0]    y_in,
    input  logic [WEIGHT_W-1:0] w_in,
    input  logic                w_load,
    input  logic                w_commit,
    output logic [DATA_W-1:0]   x_out,
    output logic                x_valid_out,
    output logic [ACC_W-1:0]    y_out,
    output logic                y_valid_out,
    output logic                sat_out
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("proc_elem_pipe: ACC_W must be >= DATA_W+WEIGHT_W");
    end
    if (X_DELAY < 1 || X_DELAY > 4) begin : g_bad_x_delay
        $error("proc_elem_pipe: X_DELAY must be in 1..4");
    end

    logic [WEIGHT_W-1:0] w_shadow;
    logic [WEIGHT_W-1:0] w_act;

    pe_weight_buf #(
        .WEIGHT_W (WEIGHT_W)
    ) u_wbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_in     (w_in),
        .w_load   (w_load),
        .w_commit (w_commit),
        .w_shadow (w_shadow),
        .w_act    (w_act)
    );

    // Shadow is only observed by the array loader; nothing here consumes it.
    logic unused_shadow;
    assign unused_shadow = ^w_shadow;

    // ---------------- x passthrough ----------------
    logic [X_DELAY-1:0] xv_q, xv_d;
    logic [DATA_W-1:0]  xd_q [X_DELAY];
    logic [DATA_W-1:0]  xd_d [X_DELAY];

    // Shift {valid, data} one place per enabled cycle; data moves only with valid.
    always_comb begin
        xv_d = xv_q;
        xd_d = xd_q;
        if (en) begin
            xv_d[0] = x_valid_in;
            if (x_valid_in) begin
                xd_d[0] = x_in;
            end
            for (int unsigned i = 1; i < X_DELAY; i++) begin
                xv_d[i] = xv_q[i-1];
                if (xv_q[i-1]) begin
                    xd_d[i] = xd_q[i-1];
                end
            end
        end
    end

    // x delay line registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xv_q <= '0;
            for (int unsigned i = 0; i < X_DELAY; i++) begin
                xd_q[i] <= '0;
            end
        end else begin
            xv_q <= xv_d;
            xd_q <= xd_d;
        end
    end

    assign x_out       = xd_q[X_DELAY-1];
    assign x_valid_out = xv_q[X_DELAY-1];

    // ---------------- MAC pipeline ----------------
    logic                     v1_q, v1_d;
    logic signed [PROD_W-1:0] p1_q, p1_d;
    logic signed [ACC_W-1:0]  y1_q, y1_d;
    logic                     yv_q, yv_d;
    logic signed [ACC_W-1:0]  yo_q, yo_d;
`ifdef PE_SAT_EN
    logic                     sat_q, sat_d;
    logic signed [ACC_W:0]    sum_w;
`endif

    // Stage 1 multiplies with the active weight; stage 2 accumulates.
    always_comb begin
        v1_d = v1_q;
        p1_d = p1_q;
        y1_d = y1_q;
        yv_d = yv_q;
        yo_d = yo_q;
`ifdef PE_SAT_EN
        sat_d = sat_q;
        sum_w = (ACC_W+1)'(y1_q) + (ACC_W+1)'(p1_q);
`endif
        if (en) begin
            v1_d = x_valid_in;
            if (x_valid_in) begin
                p1_d = PROD_W'($signed(x_in)) * PROD_W'($signed(w_act));
                y1_d = $signed(y_in);
            end
            yv_d = v1_q;
`ifdef PE_SAT_EN
            sat_d = 1'b0;
            if (v1_q) begin
                if (longint'(sum_w) > sat_max(ACC_W)) begin
                    yo_d  = ACC_W'(sat_max(ACC_W));
                    sat_d = 1'b1;
                end else if (longint'(sum_w) < sat_min(ACC_W)) begin
                    yo_d  = ACC_W'(sat_min(ACC_W));
                    sat_d = 1'b1;
                end else begin
                    yo_d = ACC_W'(sum_w);
                end
            end
`else
            if (v1_q) begin
                yo_d = y1_q + ACC_W'(p1_q);
            end
`endif
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            p1_q <= '0;
            y1_q <= '0;
            yv_q <= 1'b0;
            yo_q <= '0;
`ifdef PE_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            v1_q <= v1_d;
            p1_q <= p1_d;
            y1_q <= y1_d;
            yv_q <= yv_d;
            yo_q <= yo_d;
`ifdef PE_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign y_out       = yo_q;
    assign y_valid_out = yv_q;
`ifdef PE_SAT_EN
    assign sat_out = sat_q;
`else
    assign sat_out = 1'b0;
`endif

endmodule

// File: tb/tb_proc_elem_pipe.sv
// Directed self-checking bench for proc_elem_pipe (DATA_W=8, WEIGHT_W=8,
// ACC_W=16, X_DELAY=1). Expectations follow PE_SAT_EN when it is defined.
module tb_proc_elem_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  x_in;
    logic        x_valid_in;
    logic [15:0] y_in;
    logic [7:0]  w_in;
    logic        w_load;
    logic        w_commit;
    logic [7:0]  x_out;
    logic        x_valid_out;
    logic [15:0] y_out;
    logic        y_valid_out;
    logic        sat_out;

    int n_total = 0;
    int n_pass  = 0;

    proc_elem_pipe #(
        .DATA_W   (8),
        .WEIGHT_W (8),
        .ACC_W    (16),
        .X_DELAY  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .x_in        (x_in),
        .x_valid_in  (x_valid_in),
        .y_in        (y_in),
        .w_in        (w_in),
        .w_load      (w_load),
        .w_commit    (w_commit),
        .x_out       (x_out),
        .x_valid_out (x_valid_out),
        .y_out       (y_out),
        .y_valid_out (y_valid_out),
        .sat_out     (sat_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic chk_y(input string tag, input int yexp, input logic vexp);
        chk({tag, "_y"}, 32'($signed(y_out)), yexp);
        chk({tag, "_yv"}, {31'd0, y_valid_out}, {31'd0, vexp});
    endtask

    task automatic chk_x(input string tag, input int xexp, input logic vexp);
        chk({tag, "_x"}, 32'($signed(x_out)), xexp);
        chk({tag, "_xv"}, {31'd0, x_valid_out}, {31'd0, vexp});
    endtask

    task automatic drive(input logic v, input int x, input int y);
        x_valid_in = v;
        x_in       = 8'(x);
        y_in       = 16'(y);
    endtask

    // Load and commit in the same cycle (bypass path).
    task automatic wbypass(input int w);
        w_in     = 8'(w);
        w_load   = 1'b1;
        w_commit = 1'b1;
        tick();
        w_load   = 1'b0;
        w_commit = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        w_in     = '0;
        w_load   = 1'b0;
        w_commit = 1'b0;
        drive(1'b0, 0, 0);
        tick();
        tick();
        chk_y("rst0", 0, 1'b0);
        chk_x("rst0", 0, 1'b0);
        chk("rst0_sat", {31'd0, sat_out}, 32'd0);
        rst_n = 1'b1;

        // Load 3, commit separately, then one sample.
        w_in = 8'd3; w_load = 1'b1;
        tick();
        w_load = 1'b0; w_commit = 1'b1;
        tick();
        w_commit = 1'b0;
        drive(1'b1, 5, 10);
        tick();
        chk_x("t2_1", 5, 1'b1);
        chk("t2_1_yv", {31'd0, y_valid_out}, 32'd0);
        drive(1'b0, 0, 0);
        tick();
        chk_y("t2_2", 25, 1'b1);
        chk("t2_2_xv", {31'd0, x_valid_out}, 32'd0);
        tick();
        chk_y("t2_3", 25, 1'b0);

        // Signed extremes.
        wbypass(-2);
        drive(1'b1, -128, 0);
        tick();
        drive(1'b0, 0, 0);
        tick();
        chk_y("t3a", 256, 1'b1);
        wbypass(-128);
        drive(1'b1, -128, 0);
        tick();
        drive(1'b0, 0, 0);
        tick();
        chk_y("t3b", 16384, 1'b1);

        // Overflow boundaries.
        wbypass(1);
        drive(1'b1, 1, 32767);
        tick();
        drive(1'b1, -1, -32768);
        tick();
`ifdef PE_SAT_EN
        chk_y("t4a", 32767, 1'b1);
        chk("t4a_sat", {31'd0, sat_out}, 32'd1);
`else
        chk_y("t4a", -32768, 1'b1);
        chk("t4a_sat", {31'd0, sat_out}, 32'd0);
`endif
        drive(1'b0, 0, 0);
        tick();
`ifdef PE_SAT_EN
        chk_y("t4b", -32768, 1'b1);
        chk("t4b_sat", {31'd0, sat_out}, 32'd1);
`else
        chk_y("t4b", 32767, 1'b1);
        chk("t4b_sat", {31'd0, sat_out}, 32'd0);
`endif
        tick();
        chk("t4c_sat", {31'd0, sat_out}, 32'd0);

        // Asynchronous reset mid-stream; weights must clear as well.
        drive(1'b1, 3, 50);
        tick();
        drive(1'b1, 6, 60);
        tick();
        chk_y("t1_pre", 53, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_y("t1_async", 0, 1'b0);
        chk_x("t1_async", 0, 1'b0);
        chk("t1_async_sat", {31'd0, sat_out}, 32'd0);
        drive(1'b0, 0, 0);
        #1 rst_n = 1'b1;
        drive(1'b1, 4, 100);
        tick();
        drive(1'b0, 0, 0);
        tick();
        chk_y("t1_post", 100, 1'b1);

        // Stall for 3 cycles with samples in flight.
        wbypass(2);
        drive(1'b1, 1, 10);
        tick();
        drive(1'b1, 2, 20);
        tick();
        chk_y("t5_0", 12, 1'b1);
        chk_x("t5_0", 2, 1'b1);
        en = 1'b0;
        drive(1'b1, 3, 30);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_y("t5_stall", 12, 1'b1);
            chk_x("t5_stall", 2, 1'b1);
        end
        en = 1'b1;
        tick();
        chk_y("t5_1", 24, 1'b1);
        chk_x("t5_1", 3, 1'b1);
        drive(1'b1, 4, 40);
        tick();
        chk_y("t5_2", 36, 1'b1);
        drive(1'b0, 0, 0);
        tick();
        chk_y("t5_3", 48, 1'b1);
        chk_x("t5_3", 4, 1'b0);
        tick();
        chk_y("t5_4", 48, 1'b0);

        // Weight switching around in-flight samples.
        wbypass(7);
        drive(1'b1, 2, 0);
        tick();
        w_in = 8'd9; w_load = 1'b1; w_commit = 1'b1;
        drive(1'b1, 3, 1);
        tick();
        w_load = 1'b0; w_commit = 1'b0;
        chk_y("t6_a", 14, 1'b1);
        drive(1'b1, 3, 1);
        tick();
        chk_y("t6_b", 22, 1'b1);
        drive(1'b0, 0, 0);
        tick();
        chk_y("t6_c", 28, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
